// File: rtl/host_rr_arbiter.sv
// Round-robin arbiter funnelling NrHosts bus hosts onto one device port, one transaction outstanding.
// Grant and response are combinational; losers keep requesting while a transaction is outstanding.
module host_rr_arbiter #(
    parameter int unsigned NrHosts      = 2,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned RspTimeout   = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      host_req_i    [NrHosts],
    input  logic                      host_we_i     [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
    output logic                      host_gnt_o    [NrHosts],
    output logic                      host_rvalid_o [NrHosts],
    output logic                      host_err_o    [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],

    output logic                      device_req_o,
    output logic                      device_we_o,
    output logic [AddressWidth-1:0]   device_addr_o,
    output logic [DataWidth/8-1:0]    device_be_o,
    output logic [DataWidth-1:0]      device_wdata_o,
    input  logic                      device_rvalid_i,
    input  logic                      device_err_i,
    input  logic [DataWidth-1:0]      device_rdata_i
);

    localparam int unsigned PtrW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned CntW = (RspTimeout > 0) ? $clog2(RspTimeout + 1) : 1;
    localparam logic [CntW-1:0] CntMax   = (RspTimeout > 0) ? CntW'(RspTimeout - 1) : '0;
    localparam logic [PtrW-1:0] LastHost = PtrW'(NrHosts - 1);

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [PtrW-1:0] winner, winner_hi, winner_lo;
    logic            found_hi, found_lo, found;
    logic            timeout, rsp_done, grant;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        winner_hi = '0;
        winner_lo = '0;
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        for (int j = int'(NrHosts) - 1; j >= 0; j--) begin
            if (host_req_i[j]) begin
                winner_lo = PtrW'(j);
                found_lo  = 1'b1;
                if (PtrW'(j) >= ptr_q) begin
                    winner_hi = PtrW'(j);
                    found_hi  = 1'b1;
                end
            end
        end
        winner = found_hi ? winner_hi : winner_lo;
        found  = found_lo;
    end

    assign timeout  = (RspTimeout != 0) && (state_q == StWait) && !device_rvalid_i &&
                      (cnt_q == CntMax);
    assign rsp_done = (state_q == StWait) && (device_rvalid_i || timeout);
    // Gated by rst_ni so nothing leaks out combinationally while reset is held.
    assign grant    = rst_ni && found && ((state_q == StIdle) || rsp_done);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (grant) begin
            state_d = StWait;
            owner_d = winner;
            ptr_d   = (winner == LastHost) ? '0 : winner + 1'b1;
            cnt_d   = '0;
        end else if (rsp_done) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if ((state_q == StWait) && (RspTimeout != 0)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        device_req_o   = grant;
        device_we_o    = 1'b0;
        device_addr_o  = '0;
        device_be_o    = '0;
        device_wdata_o = '0;
        for (int i = 0; i < int'(NrHosts); i++) begin
            host_gnt_o[i] = grant && (winner == PtrW'(i));
            if (host_gnt_o[i]) begin
                device_we_o    = host_we_i[i];
                device_addr_o  = host_addr_i[i];
                device_be_o    = host_be_i[i];
                device_wdata_o = host_wdata_i[i];
            end
        end
    end

    // A timed-out response reports an error with zero data; a real response passes through.
    always_comb begin
        for (int i = 0; i < int'(NrHosts); i++) begin
            host_rvalid_o[i] = rsp_done && (owner_q == PtrW'(i));
            host_err_o[i]    = 1'b0;
            host_rdata_o[i]  = '0;
            if (host_rvalid_o[i]) begin
                host_err_o[i]   = device_rvalid_i ? device_err_i : 1'b1;
                host_rdata_o[i] = device_rvalid_i ? device_rdata_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_host_rr_arbiter.sv
module tb_host_rr_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] W0 = 32'hAAAA_0000;
    localparam logic [31:0] W1 = 32'h1234_5678;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        host_req_i    [2];
    logic        host_we_i     [2];
    logic [31:0] host_addr_i   [2];
    logic [3:0]  host_be_i     [2];
    logic [31:0] host_wdata_i  [2];
    logic        host_gnt_o    [2];
    logic        host_rvalid_o [2];
    logic        host_err_o    [2];
    logic [31:0] host_rdata_o  [2];
    logic        device_req_o, device_we_o;
    logic [31:0] device_addr_o, device_wdata_o;
    logic [3:0]  device_be_o;
    logic        device_rvalid_i, device_err_i;
    logic [31:0] device_rdata_i;

    host_rr_arbiter #(
        .NrHosts(2), .DataWidth(32), .AddressWidth(32), .RspTimeout(15)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
        .host_err_o(host_err_o), .host_rdata_o(host_rdata_o),
        .device_req_o(device_req_o), .device_we_o(device_we_o),
        .device_addr_o(device_addr_o), .device_be_o(device_be_o),
        .device_wdata_o(device_wdata_o), .device_rvalid_i(device_rvalid_i),
        .device_err_i(device_err_i), .device_rdata_i(device_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // One cycle of stimulus plus the outputs it must produce; bit [1] is host1.
    typedef struct {
        logic [1:0]  req;
        logic        we1;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  gnt;
        logic [1:0]  hrv;
        logic [1:0]  herr;
        logic [31:0] hrdata;
    } vec_t;

    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  hrv;
        logic [1:0]  herr;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [3:0]  dbe;
        logic [31:0] dwd;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t tbl[11];
    vec_t zv;

    function automatic exp_t mk(input vec_t v);
        exp_t e;
        e.gnt   = v.gnt;
        e.hrv   = v.hrv;
        e.herr  = v.herr;
        e.rd0   = v.hrv[0] ? v.hrdata : 32'h0;
        e.rd1   = v.hrv[1] ? v.hrdata : 32'h0;
        e.dreq  = |v.gnt;
        e.dwe   = 1'b0;
        e.daddr = 32'h0;
        e.dbe   = 4'h0;
        e.dwd   = 32'h0;
        if (v.gnt[0]) begin
            e.daddr = A0;
            e.dbe   = 4'hF;
            e.dwd   = W0;
        end else if (v.gnt[1]) begin
            e.dwe   = v.we1;
            e.daddr = A1;
            e.dbe   = 4'b0011;
            e.dwd   = W1;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_inputs(input vec_t v);
        host_req_i[0]   = v.req[0];
        host_req_i[1]   = v.req[1];
        host_we_i[0]    = 1'b0;
        host_we_i[1]    = v.we1;
        device_rvalid_i = v.rv;
        device_err_i    = v.err;
        device_rdata_i  = v.rdata;
    endtask

    task automatic check_now(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({nm, ".scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({nm, ".gnt"},    32'({host_gnt_o[1], host_gnt_o[0]}), 32'(e.gnt));
        chk({nm, ".rvalid"}, 32'({host_rvalid_o[1], host_rvalid_o[0]}), 32'(e.hrv));
        chk({nm, ".err"},    32'({host_err_o[1], host_err_o[0]}), 32'(e.herr));
        chk({nm, ".rdata0"}, host_rdata_o[0], e.rd0);
        chk({nm, ".rdata1"}, host_rdata_o[1], e.rd1);
        chk({nm, ".dev_req"}, 32'(device_req_o), 32'(e.dreq));
        chk({nm, ".dev_we"},  32'(device_we_o), 32'(e.dwe));
        chk({nm, ".dev_addr"}, device_addr_o, e.daddr);
        chk({nm, ".dev_be"},  32'(device_be_o), 32'(e.dbe));
        chk({nm, ".dev_wdata"}, device_wdata_o, e.dwd);
    endtask

    // Called just after a rising edge; leaves time just after the next rising edge.
    task automatic cycle(input vec_t v, input string nm);
        drive_inputs(v);
        exp_q.push_back(mk(v));
        @(negedge clk_i);
        check_now(nm);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        zv = '{2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0};
        //          req    we1   rv    err   rdata        gnt    hrv    herr   hrdata
        tbl[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b00, 32'h0};
        tbl[1]  = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h0,  2'b10, 2'b00, 2'b00, 32'h0};
        tbl[2]  = '{2'b01, 1'b0, 1'b1, 1'b0, 32'h11, 2'b01, 2'b10, 2'b00, 32'h11};
        tbl[3]  = '{2'b11, 1'b0, 1'b1, 1'b0, 32'h22, 2'b10, 2'b01, 2'b00, 32'h22};
        tbl[4]  = '{2'b11, 1'b0, 1'b1, 1'b0, 32'h33, 2'b01, 2'b10, 2'b00, 32'h33};
        tbl[5]  = '{2'b11, 1'b0, 1'b1, 1'b1, 32'h44, 2'b10, 2'b01, 2'b01, 32'h44};
        tbl[6]  = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b00, 32'h0};
        tbl[7]  = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h55, 2'b00, 2'b10, 2'b00, 32'h55};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 1'b1, 32'h77, 2'b00, 2'b00, 2'b00, 32'h0};
        tbl[9]  = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0,  2'b01, 2'b00, 2'b00, 32'h0};
        tbl[10] = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h66, 2'b00, 2'b01, 2'b00, 32'h66};

        host_addr_i[0]  = A0;
        host_addr_i[1]  = A1;
        host_be_i[0]    = 4'hF;
        host_be_i[1]    = 4'b0011;
        host_wdata_i[0] = W0;
        host_wdata_i[1] = W1;

        // Outputs stay quiet in reset even with every input active.
        rst_ni = 1'b0;
        drive_inputs('{2'b11, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 2'b00, 2'b00, 2'b00, 32'h0});
        #12;
        exp_q.push_back(mk(zv));
        check_now("reset");
        drive_inputs(zv);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int k = 0; k < 11; k++) cycle(tbl[k], $sformatf("vec%0d", k));

        // Silent device: error response on the 15th waiting cycle, later rvalid dropped.
        cycle('{2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 2'b00, 2'b00, 32'h0}, "to_grant");
        for (int n = 1; n <= 14; n++) cycle(zv, $sformatf("to_wait%0d", n));
        cycle('{2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b10, 2'b10, 32'h0}, "to_expire");
        cycle('{2'b00, 1'b0, 1'b1, 1'b0, 32'hBAD, 2'b00, 2'b00, 2'b00, 32'h0}, "to_late");

        // Response landing on the timeout cycle wins over the timeout.
        cycle('{2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 2'b00, 32'h0}, "edge_grant");
        for (int n = 1; n <= 14; n++) cycle(zv, $sformatf("edge_wait%0d", n));
        cycle('{2'b00, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 2'b00, 2'b01, 2'b00, 32'hDEADBEEF},
              "edge_rsp");
        cycle(zv, "edge_once");

        // Reset while waiting on host0 (ptr=1): ptr must return to 0, no stale response.
        cycle('{2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 2'b00, 32'h0}, "rst_grant");
        drive_inputs('{2'b11, 1'b0, 1'b1, 1'b0, 32'h99, 2'b00, 2'b00, 2'b00, 32'h0});
        rst_ni = 1'b0;
        #1;
        exp_q.push_back(mk(zv));
        check_now("rst_async");
        drive_inputs('{2'b00, 1'b0, 1'b1, 1'b0, 32'h99, 2'b00, 2'b00, 2'b00, 32'h0});
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cycle('{2'b00, 1'b0, 1'b1, 1'b0, 32'h99, 2'b00, 2'b00, 2'b00, 32'h0}, "rst_stale");
        cycle('{2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 2'b00, 32'h0}, "rst_ptr");
        cycle('{2'b00, 1'b0, 1'b1, 1'b0, 32'hAB, 2'b00, 2'b01, 2'b00, 32'hAB}, "rst_rsp");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
